picomem_mux_1_n: RTL and testbench
==================================

# picomem_mux_1_n

Parametrised 1-to-N PicoRV32 native-memory-bus demultiplexer. It sits between the core's `mem_*` port and up to 16 peripheral/memory slaves. It decodes the master address against per-slave base/mask pairs with fixed priority and latches the selected slave for the whole transaction. Unmapped accesses and, optionally, hung slaves complete with a default read word and are logged in sticky error registers.

## Interface
- `N_SLAVES`, default 8: number of slave ports, legal range 2..16.
- `ADDR_BASE`, default {8{32'h0}}: packed N_SLAVES×32 bit base addresses; slave i uses bits [32i+31:32i].
- `ADDR_MASK`, default {8{32'h0F00_0000}}: packed N_SLAVES×32 bit compare masks; slave i matches when ((addr ^ base_i) & mask_i) == 0.
- `TIMEOUT_CYCLES`, default 256: maximum cycles a selected slave may hold off `ready`; legal range 2..65535.
- `DEFAULT_RDATA`, default 32'hDEAD_BEEF: read data returned on an unmapped or timed-out access.
- `clk` in 1: system clock. One clock domain; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `picom_valid` in 1; `picom_addr` in 32; `picom_wdata` in 32; `picom_wstrb` in 4: master request.
- `picom_ready` out 1; `picom_rdata` out 32: master response.
- `picos_valid` out N_SLAVES: one-hot slave request.
- `picos_addr` out 32; `picos_wdata` out 32; `picos_wstrb` out 4: broadcast copies of the master request fields.
- `picos_ready` in N_SLAVES; `picos_rdata` in N_SLAVES×32: slave responses, packed like `ADDR_BASE`.
- `err_valid` out 1: sticky error flag.
- `err_timeout` out 1: error cause; 1 = timeout, 0 = unmapped.
- `err_addr` out 32: address of the first logged error.
- `err_clear` in 1: single-cycle pulse that clears the error registers.

## Operation
- States: IDLE, BUSY, ERR.
- IDLE:
  - `picom_valid`=1 with at least one match → latch sel = lowest matching index, clear the counter, go to BUSY.
  - `picom_valid`=1 with no match → go to ERR.
  - `picom_valid`=0 → stay in IDLE.
- BUSY:
  - `picos_valid[sel]`=1; all other bits 0.
  - `picom_ready` = `picos_ready[sel]` and `picom_rdata` = `picos_rdata[sel]`, combinational passthrough.
  - When `picos_ready[sel]`=1 → go to IDLE.
  - If `picom_valid` drops (protocol violation) → abort to IDLE with no error logged.
- ERR: lasts one cycle. `picom_ready`=1, `picom_rdata`=`DEFAULT_RDATA`, then go to IDLE. Log an unmapped error.
- `picos_ready` bits of unselected slaves are ignored.
- `picom_rdata` = 0 whenever `picom_ready`=0.
- Write accesses behave the same as reads; a write completed by ERR or timeout is dropped.
- Error logging:
  - When `err_valid`=0: set `err_valid`, capture `err_addr` = `picom_addr` and the cause.
  - When `err_valid`=1: later errors are ignored; the first error is kept.
  - `err_clear` zeroes all three error outputs. If `err_clear` and a new error occur in the same cycle, the new error is logged.
- Reset values: state IDLE, `picos_valid`=0, `picom_ready`=0, `picom_rdata`=0, `err_valid`=0, `err_timeout`=0, `err_addr`=0, counter 0.
- Reset asserted mid-transaction: `picos_valid` is low in the following cycle, no `picom_ready` is produced, and no error is logged.

## Timing
- Master `valid` sampled in IDLE at edge T → `picos_valid[sel]` high in cycle T+1 (one registered decode cycle).
- Slave `ready` in cycle k ≥ T+1 → `picom_ready` in the same cycle k; back in IDLE at k+1. A new master `valid` in cycle k+1 is accepted.
- Zero-wait-state slave: master sees `ready` 1 cycle after `valid`.
- Unmapped access: `picom_ready` in cycle T+1.
- Timeout:
  - The counter increments each BUSY cycle without `ready`.
  - In the BUSY cycle where the count equals TIMEOUT_CYCLES−1 and the slave is not ready, the block forces `picom_ready`=1 with `DEFAULT_RDATA` and logs a timeout.
  - `picos_valid` is low from the next cycle.
  - If slave `ready` arrives in that same cycle, the slave wins: its data is returned and nothing is logged.
- Counter width is $clog2(TIMEOUT_CYCLES); it never wraps because it is cleared on entry to BUSY.

## Configuration
- `PICOMEM_MUX_TIMEOUT_EN` defined: the timeout counter and timeout logging are present.
- `PICOMEM_MUX_TIMEOUT_EN` undefined:
  - No counter; BUSY waits indefinitely.
  - `err_timeout` is tied to 0; `TIMEOUT_CYCLES` is ignored.
  - Unmapped handling is unchanged.

## Structure
- Package `picomem_pkg` holds:
  - `PICOMEM_ADDR_W`=32, `PICOMEM_DATA_W`=32, `PICOMEM_STRB_W`=4;
  - the `picomem_mux_state_t` enum (IDLE/BUSY/ERR);
  - `PICOMEM_MAX_SLAVES`=16.
- Sub-module `picomem_addr_decode`: purely combinational. Takes the address plus packed base/mask and outputs `hit` and the `sel` index (lowest index wins).

## Test plan
- Slave 2 at 0x8200_0000, read of 0x8200_0010, `picos_ready[2]` after 3 wait cycles → `picom_ready` 4 cycles after `valid`, with `picom_rdata` equal to the slave 2 data.
- Overlapping matches: slaves 1 and 5 both map 0x8100_0000; access that address → only `picos_valid[1]` asserted.
- Unmapped 0x1234_5678 → `picom_ready` at T+1 with rdata 0xDEAD_BEEF; `err_valid`=1, `err_timeout`=0, `err_addr`=0x1234_5678; a second unmapped access leaves `err_addr` unchanged.
- Timeout test (macro on, TIMEOUT_CYCLES=4): selected slave never ready → `picom_ready` in the 4th BUSY cycle with 0xDEAD_BEEF and `err_timeout`=1. Repeat with slave `ready` arriving in that same cycle → slave data returned, no error logged.
- `rst` asserted during BUSY → `picos_valid`=0 next cycle and all outputs at reset values. Then `err_clear` pulsed in the same cycle as an unmapped access → the new error is logged.

Source files
------------

// File: rtl/picomem_pkg.sv
// Shared widths, limits and FSM state type for the PicoRV32 native-bus mux.
`timescale 1ns/1ps
package picomem_pkg;

    localparam int PICOMEM_ADDR_W     = 32;
    localparam int PICOMEM_DATA_W     = 32;
    localparam int PICOMEM_STRB_W     = 4;
    localparam int PICOMEM_MAX_SLAVES = 16;
    localparam int PICOMEM_SEL_W      = $clog2(PICOMEM_MAX_SLAVES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } picomem_mux_state_t;

endpackage

// File: rtl/picomem_mux_1_n_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
`timescale 1ns/1ps
module picomem_addr_decode
    import picomem_pkg::*;
#(
    parameter int N_SLAVES = 8
) (
    input  logic [PICOMEM_ADDR_W-1:0]          i_addr,
    input  logic [N_SLAVES*PICOMEM_ADDR_W-1:0] i_base,
    input  logic [N_SLAVES*PICOMEM_ADDR_W-1:0] i_mask,
    output logic                               o_hit,
    output logic [PICOMEM_SEL_W-1:0]           o_sel
);

    logic [N_SLAVES-1:0] w_match;

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_match
            assign w_match[gi] =
                ((i_addr ^ i_base[gi*PICOMEM_ADDR_W +: PICOMEM_ADDR_W]) &
                 i_mask[gi*PICOMEM_ADDR_W +: PICOMEM_ADDR_W]) == '0;
        end
    endgenerate

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        o_hit = |w_match;
        o_sel = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_sel = PICOMEM_SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/picomem_mux_1_n.sv
// 1-to-N PicoRV32 native memory bus demultiplexer with sticky error logging.
// Optional slave hang timeout is enabled by defining PICOMEM_MUX_TIMEOUT_EN.
`timescale 1ns/1ps
module picomem_mux_1_n
    import picomem_pkg::*;
#(
    parameter int                               N_SLAVES       = 8,
    parameter logic [N_SLAVES*PICOMEM_ADDR_W-1:0] ADDR_BASE    = {N_SLAVES{32'h0000_0000}},
    parameter logic [N_SLAVES*PICOMEM_ADDR_W-1:0] ADDR_MASK    = {N_SLAVES{32'h0F00_0000}},
    parameter int                               TIMEOUT_CYCLES = 256,
    parameter logic [PICOMEM_DATA_W-1:0]        DEFAULT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               picom_valid,
    input  logic [PICOMEM_ADDR_W-1:0]          picom_addr,
    input  logic [PICOMEM_DATA_W-1:0]          picom_wdata,
    input  logic [PICOMEM_STRB_W-1:0]          picom_wstrb,
    output logic                               picom_ready,
    output logic [PICOMEM_DATA_W-1:0]          picom_rdata,
    output logic [N_SLAVES-1:0]                picos_valid,
    output logic [PICOMEM_ADDR_W-1:0]          picos_addr,
    output logic [PICOMEM_DATA_W-1:0]          picos_wdata,
    output logic [PICOMEM_STRB_W-1:0]          picos_wstrb,
    input  logic [N_SLAVES-1:0]                picos_ready,
    input  logic [N_SLAVES*PICOMEM_DATA_W-1:0] picos_rdata,
    output logic                               err_valid,
    output logic                               err_timeout,
    output logic [PICOMEM_ADDR_W-1:0]          err_addr,
    input  logic                               err_clear
);

    picomem_mux_state_t              r_state;
    picomem_mux_state_t              w_state_next;
    logic [PICOMEM_SEL_W-1:0]        r_sel;
    logic [PICOMEM_ADDR_W-1:0]       r_req_addr;
    logic                            r_err_valid;
    logic                            r_err_timeout;
    logic [PICOMEM_ADDR_W-1:0]       r_err_addr;

    logic                            w_dec_hit;
    logic [PICOMEM_SEL_W-1:0]        w_dec_sel;
    logic                            w_busy;
    logic                            w_sel_ready;
    logic [PICOMEM_DATA_W-1:0]       w_sel_rdata;
    logic                            w_timeout;
    logic                            w_err_event;

    logic [PICOMEM_MAX_SLAVES-1:0]   w_ready_pad;
    logic [PICOMEM_DATA_W-1:0]       w_rdata_pad [PICOMEM_MAX_SLAVES];

    picomem_addr_decode #(
        .N_SLAVES (N_SLAVES)
    ) u_decode (
        .i_addr (picom_addr),
        .i_base (ADDR_BASE),
        .i_mask (ADDR_MASK),
        .o_hit  (w_dec_hit),
        .o_sel  (w_dec_sel)
    );

    // Pad slave responses to the full select range so r_sel indexes cleanly.
    generate
        for (genvar gi = 0; gi < PICOMEM_MAX_SLAVES; gi++) begin : g_pad
            if (gi < N_SLAVES) begin : g_real
                assign w_ready_pad[gi] = picos_ready[gi];
                assign w_rdata_pad[gi] = picos_rdata[gi*PICOMEM_DATA_W +: PICOMEM_DATA_W];
            end else begin : g_none
                assign w_ready_pad[gi] = 1'b0;
                assign w_rdata_pad[gi] = '0;
            end
        end
    endgenerate

    assign w_busy      = (r_state == BUSY);
    assign w_sel_ready = w_ready_pad[r_sel];
    assign w_sel_rdata = w_rdata_pad[r_sel];

`ifdef PICOMEM_MUX_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // A ready slave in the final cycle still wins over the forced completion.
    assign w_timeout = w_busy & picom_valid & ~w_sel_ready & (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_busy) begin
            r_cnt <= '0;
        end else if (!w_sel_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_req_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && picom_valid) begin
                r_req_addr <= picom_addr;
                if (w_dec_hit) begin
                    r_sel <= w_dec_sel;
                end
            end
        end
    end

    // Next-state logic; a dropped master valid aborts BUSY silently.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (picom_valid) begin
                    w_state_next = w_dec_hit ? BUSY : ERR;
                end
            end
            BUSY: begin
                if (!picom_valid || w_sel_ready || w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic; responses are suppressed while reset is asserted.
    always_comb begin
        picom_ready = 1'b0;
        picom_rdata = '0;
        if (!rst) begin
            case (r_state)
                BUSY: begin
                    if (w_sel_ready) begin
                        picom_ready = 1'b1;
                        picom_rdata = w_sel_rdata;
                    end else if (w_timeout) begin
                        picom_ready = 1'b1;
                        picom_rdata = DEFAULT_RDATA;
                    end
                end
                ERR: begin
                    picom_ready = 1'b1;
                    picom_rdata = DEFAULT_RDATA;
                end
                default: begin
                    picom_ready = 1'b0;
                    picom_rdata = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_valid
            assign picos_valid[gi] = w_busy & (r_sel == PICOMEM_SEL_W'(gi));
        end
    endgenerate

    assign picos_addr  = picom_addr;
    assign picos_wdata = picom_wdata;
    assign picos_wstrb = picom_wstrb;

    assign w_err_event = (r_state == ERR) | w_timeout;

    // First error sticks; a clear coinciding with a new error logs the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_addr    <= '0;
        end else if (w_err_event && (!r_err_valid || err_clear)) begin
            r_err_valid   <= 1'b1;
            r_err_timeout <= w_timeout;
            r_err_addr    <= r_req_addr;
        end else if (err_clear) begin
            r_err_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_addr    <= '0;
        end
    end

    assign err_valid   = r_err_valid;
    assign err_timeout = r_err_timeout;
    assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_picomem_mux_1_n.sv
// Randomised self-checking bench for picomem_mux_1_n against a transaction-level model.
`timescale 1ns/1ps
module tb_picomem_mux_1_n;

    localparam int N  = 8;
    localparam int TO = 4;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
`ifdef PICOMEM_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Slave 7 overlaps 1,2,3,5; slave 5 duplicates slave 1.
    localparam logic [N*32-1:0] BASES = {32'h8000_0000, 32'hA000_0000, 32'h8100_0000, 32'h9000_0000,
                                         32'h8300_0000, 32'h8200_0000, 32'h8100_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] MASKS = {32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000,
                                         32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000};

    logic          clk;
    logic          rst;
    logic          picom_valid;
    logic [31:0]   picom_addr;
    logic [31:0]   picom_wdata;
    logic [3:0]    picom_wstrb;
    logic          picom_ready;
    logic [31:0]   picom_rdata;
    logic [N-1:0]  picos_valid;
    logic [31:0]   picos_addr;
    logic [31:0]   picos_wdata;
    logic [3:0]    picos_wstrb;
    logic [N-1:0]  picos_ready;
    logic [N*32-1:0] picos_rdata;
    logic          err_valid;
    logic          err_timeout;
    logic [31:0]   err_addr;
    logic          err_clear;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_base [N];
    logic [31:0] m_mask [N];
    bit          m_err_v;
    bit          m_err_to;
    logic [31:0] m_err_addr;

    picomem_mux_1_n #(
        .N_SLAVES       (N),
        .ADDR_BASE      (BASES),
        .ADDR_MASK      (MASKS),
        .TIMEOUT_CYCLES (TO),
        .DEFAULT_RDATA  (DEAD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .picom_valid (picom_valid),
        .picom_addr  (picom_addr),
        .picom_wdata (picom_wdata),
        .picom_wstrb (picom_wstrb),
        .picom_ready (picom_ready),
        .picom_rdata (picom_rdata),
        .picos_valid (picos_valid),
        .picos_addr  (picos_addr),
        .picos_wdata (picos_wdata),
        .picos_wstrb (picos_wstrb),
        .picos_ready (picos_ready),
        .picos_rdata (picos_rdata),
        .err_valid   (err_valid),
        .err_timeout (err_timeout),
        .err_addr    (err_addr),
        .err_clear   (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_sel(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if (((a ^ m_base[i]) & m_mask[i]) == 32'h0) return i;
        end
        return -1;
    endfunction

    task automatic model_log(input bit ev, input bit is_to, input logic [31:0] a, input bit clr);
        if (ev && (!m_err_v || clr)) begin
            m_err_v = 1'b1; m_err_to = is_to; m_err_addr = a;
        end else if (clr) begin
            m_err_v = 1'b0; m_err_to = 1'b0; m_err_addr = '0;
        end
    endtask

    // One master transaction; starts and ends 1 ns after a rising edge.
    task automatic do_txn(input logic [31:0] a, input int waits, input bit clr_at_resp);
        int          sel;
        logic [31:0] sdata [N];
        logic [N-1:0] noise;
        logic [N-1:0] exp_v;
        logic [31:0] exp_rdata;
        bit          exp_ready;
        bit          done;
        bit          ev;
        bit          is_to;
        sel = ref_sel(a);
        picom_valid = 1'b1;
        picom_addr  = a;
        picom_wdata = $urandom;
        picom_wstrb = 4'($urandom_range(0, 15));
        for (int i = 0; i < N; i++) begin
            sdata[i] = $urandom;
            picos_rdata[i*32 +: 32] = sdata[i];
        end
        picos_ready = N'($urandom);
        @(negedge clk);
        n_vec++;
        if ({picom_ready, picos_valid} !== '0) begin
            n_err++;
            $display("FAIL accept_cycle addr=%h: ready=%b valid=%b, expected 0/0", a, picom_ready, picos_valid);
        end
        @(posedge clk); #1;
        ev = 1'b0; is_to = 1'b0;
        if (sel < 0) begin
            err_clear = clr_at_resp;
            @(negedge clk);
            n_vec++;
            if ({picom_ready, picom_rdata, picos_valid} !== {1'b1, DEAD, N'(0)}) begin
                n_err++;
                $display("FAIL unmapped_resp addr=%h: ready=%b rdata=%h valid=%b, expected 1 %h 0",
                         a, picom_ready, picom_rdata, picos_valid, DEAD);
            end
            ev = 1'b1;
        end else begin
            done  = 1'b0;
            exp_v = N'(1) << sel;
            for (int c = 0; c < 12 && !done; c++) begin
                noise      = N'($urandom);
                noise[sel] = (c == waits);
                picos_ready = noise;
                exp_ready  = (c == waits) || (TO_EN && c == TO - 1);
                is_to      = TO_EN && (c == TO - 1) && (c != waits);
                exp_rdata  = !exp_ready ? 32'h0 : ((c == waits) ? sdata[sel] : DEAD);
                if (exp_ready) err_clear = clr_at_resp;
                @(negedge clk);
                n_vec++;
                if ({picom_ready, picom_rdata, picos_valid, picos_addr, picos_wdata, picos_wstrb} !==
                    {exp_ready, exp_rdata, exp_v, a, picom_wdata, picom_wstrb}) begin
                    n_err++;
                    $display("FAIL busy_resp addr=%h c=%0d: ready=%b rdata=%h valid=%b paddr=%h, expected %b %h %b %h",
                             a, c, picom_ready, picom_rdata, picos_valid, picos_addr,
                             exp_ready, exp_rdata, exp_v, a);
                end
                if (exp_ready) begin
                    done = 1'b1;
                    ev   = is_to;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        model_log(ev, is_to, a, clr_at_resp);
        @(posedge clk); #1;
        picom_valid = 1'b0;
        err_clear   = 1'b0;
        picos_ready = '0;
        n_vec++;
        if ({err_valid, err_timeout, err_addr} !== {m_err_v, m_err_to, m_err_addr}) begin
            n_err++;
            $display("FAIL err_regs addr=%h: v=%b to=%b a=%h, expected v=%b to=%b a=%h",
                     a, err_valid, err_timeout, err_addr, m_err_v, m_err_to, m_err_addr);
        end
        $display("txn addr=%h sel=%0d waits=%0d clr=%0b err=%0b/%0b/%h", a, sel, waits, clr_at_resp,
                 err_valid, err_timeout, err_addr);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        model_log(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if ({err_valid, err_timeout, err_addr} !== {m_err_v, m_err_to, m_err_addr}) begin
            n_err++;
            $display("FAIL err_clear: v=%b to=%b a=%h, expected 0 0 0", err_valid, err_timeout, err_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; picom_valid = 1'b0; picom_addr = '0; picom_wdata = '0; picom_wstrb = '0;
        picos_ready = '0; picos_rdata = '0; err_clear = 1'b0;
        m_err_v = 1'b0; m_err_to = 1'b0; m_err_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({picom_ready, picom_rdata, picos_valid, err_valid, err_timeout, err_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b rdata=%h valid=%b err=%b/%b/%h, expected all 0",
                     picom_ready, picom_rdata, picos_valid, err_valid, err_timeout, err_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_txn(32'h8200_0010, 3, 1'b0);
        do_txn(32'h8100_0000, 0, 1'b0);
        do_txn(32'h8400_1234, 1, 1'b0);
        do_txn(32'h0000_0100, 0, 1'b0);
    endtask

    task automatic test_unmapped();
        do_txn(32'h1234_5678, 0, 1'b0);
        do_txn(32'h5555_0000, 0, 1'b0);
    endtask

    task automatic test_timeout();
        pulse_clear();
`ifdef PICOMEM_MUX_TIMEOUT_EN
        do_txn(32'h9000_0040, 100, 1'b0);
        pulse_clear();
        do_txn(32'h9000_0040, TO - 1, 1'b0);
`else
        do_txn(32'h9000_0040, 9, 1'b0);
`endif
    endtask

    task automatic test_reset_mid();
        picom_valid = 1'b1; picom_addr = 32'h8200_0000; picos_ready = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        picos_ready = '1;
        @(negedge clk);
        n_vec++;
        if ({picom_ready, picom_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_resp: ready=%b rdata=%h, expected 0 0", picom_ready, picom_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0; picom_valid = 1'b0; picos_ready = '0;
        m_err_v = 1'b0; m_err_to = 1'b0; m_err_addr = '0;
        @(negedge clk);
        n_vec++;
        if ({picom_ready, picom_rdata, picos_valid, err_valid, err_timeout, err_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_state: ready=%b valid=%b err=%b/%b/%h, expected all 0",
                     picom_ready, picos_valid, err_valid, err_timeout, err_addr);
        end
        @(posedge clk); #1;
        do_txn(32'h1111_0000, 0, 1'b0);
        do_txn(32'h2222_0004, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        int          w;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 8))
                0: a = {4'h0, 28'($urandom)};
                1: a = {8'h81, 24'($urandom)};
                2: a = {8'h82, 24'($urandom)};
                3: a = {8'h83, 24'($urandom)};
                4: a = {4'h9, 28'($urandom)};
                5: a = {4'hA, 28'($urandom)};
                6: a = {8'h84, 24'($urandom)};
                7: a = {4'h1, 28'($urandom)};
                default: a = {4'hF, 28'($urandom)};
            endcase
            w = $urandom_range(0, 6);
            do_txn(a, w, ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_base[i] = BASES[i*32 +: 32];
            m_mask[i] = MASKS[i*32 +: 32];
        end
        test_reset();
        test_directed();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
